// File: rtl/fft_cordic_pkg.sv
// Shared definitions for the CORDIC FFT angle path: default widths, step-table builder, sequencer states.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package fft_cordic_pkg;

    localparam int ANGLE_W_DEF = 32;
    localparam int FRAC_W_DEF  = 16;

    // pi scaled by 2^60, truncated; the next hex digits are 0x313..., so the
    // truncation error is far below anything that can change a rounded step.
    localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_t;

    // round(pi * 2^frac_w / 2^(s-1)) done as a rounded right shift of PI_Q60.
    function automatic logic [63:0] twiddle_step(input int s, input int frac_w);
        int sh;
        sh = 60 - frac_w + s - 1;
        if (s < 1 || sh < 1 || sh > 63) begin
            return 64'd0;
        end
        return (PI_Q60 + (64'd1 << (sh - 1))) >> sh;
    endfunction

endpackage

// File: rtl/angle_step_lut.sv
// Combinational STEP(s) table: angle increment per beat for stage s (entries 1..MAX_LOG2N).
// Latency: combinational.
// Backpressure: none; pure lookup. Ports: stage (4b) in, step (ANGLE_W) out; illegal stage gives 0.
module angle_step_lut
    import fft_cordic_pkg::*;
#(
    parameter int ANGLE_W   = ANGLE_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int MAX_LOG2N = 10
) (
    input  logic [3:0]         stage,
    output logic [ANGLE_W-1:0] step
);

    always_comb begin
        step = '0;
        for (int s = 1; s <= MAX_LOG2N; s++) begin
            if (int'(stage) == s) begin
                step = ANGLE_W'(twiddle_step(s, FRAC_W));
            end
        end
    end

endmodule

// File: rtl/cordic_twiddle_angle_gen.sv
// Twiddle-angle sequencer: streams -/+ k*pi/2^(s-1), k = 0..2^(s-1)-1, for the CORDIC rotator.
// Latency: first beat one cycle after an accepted start; one beat per cycle while i_ready is high.
// Backpressure: valid/ready; angle/index/last hold while o_valid & !i_ready. i_abort drops o_valid next cycle.
// Ports: i_clk, i_rst_n (async low); i_start/i_stage/i_inverse request; i_abort; i_ready;
//        o_valid/o_angle/o_index/o_last beat; o_busy (in RUN); o_err (illegal-stage start pulse).
module cordic_twiddle_angle_gen
    import fft_cordic_pkg::*;
#(
    parameter int ANGLE_W   = ANGLE_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int MAX_LOG2N = 10,
    parameter int IDX_W     = (MAX_LOG2N > 1) ? (MAX_LOG2N - 1) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [3:0]         i_stage,
    input  logic               i_inverse,
    input  logic               i_abort,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [ANGLE_W-1:0] o_angle,
    output logic [IDX_W-1:0]   o_index,
    output logic               o_last,
    output logic               o_busy,
    output logic               o_err
);

    // The accumulator peaks just below pi*2^FRAC_W, so it needs two integer
    // bits plus sign; no wrap to +/-pi is ever required.
    if (ANGLE_W < FRAC_W + 3) begin : g_bad_angle_w
        $error("cordic_twiddle_angle_gen: ANGLE_W must be at least FRAC_W+3");
    end
    if (MAX_LOG2N < 1 || MAX_LOG2N > 15) begin : g_bad_max_log2n
        $error("cordic_twiddle_angle_gen: MAX_LOG2N must be in 1..15");
    end

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    gen_state_t         state_q;
    gen_state_t         state_d;

    logic [ANGLE_W-1:0] step_lut;
    logic [ANGLE_W-1:0] step_q;
    logic [ANGLE_W-1:0] acc_q;
    logic               inv_q;
    logic               last_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_nxt;
    logic [IDX_W-1:0]   last_idx_q;
    logic [IDX_W-1:0]   last_idx_n;

    logic               stage_legal;
    logic               start_ok;
    logic               fire;

    angle_step_lut #(
        .ANGLE_W   (ANGLE_W),
        .FRAC_W    (FRAC_W),
        .MAX_LOG2N (MAX_LOG2N)
    ) u_step_lut (
        .stage (i_stage),
        .step  (step_lut)
    );

    assign stage_legal = (i_stage != 4'd0) && (int'(i_stage) <= MAX_LOG2N);

    // Abort outranks both a start and a fire in the same cycle.
    assign start_ok = (state_q == ST_IDLE) && i_start && stage_legal && !i_abort;
    assign fire     = (state_q == ST_RUN) && i_ready && !i_abort;
    assign idx_nxt  = idx_q + IDX_ONE;

    // Last index 2^(s-1)-1 is simply the low s-1 bits set.
    always_comb begin
        last_idx_n = '0;
        for (int j = 0; j < IDX_W; j++) begin
            last_idx_n[j] = (j < (int'(i_stage) - 1));
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_ok)        state_d = ST_RUN;
                ST_RUN:  if (fire && last_q)  state_d = ST_IDLE;
                default:                      state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_q     <= '0;
            acc_q      <= '0;
            inv_q      <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            last_idx_q <= '0;
        end else begin
            err_q <= (state_q == ST_IDLE) && i_start && !stage_legal && !i_abort;
            if (start_ok) begin
                step_q     <= step_lut;
                inv_q      <= i_inverse;
                last_idx_q <= last_idx_n;
                idx_q      <= '0;
                acc_q      <= '0;
                last_q     <= (last_idx_n == '0);
            end else if (fire) begin
                if (last_q) begin
                    last_q <= 1'b0;
                end else begin
                    // Accumulate rather than multiply so the sequence matches
                    // the old ROM tables bit for bit.
                    idx_q  <= idx_nxt;
                    acc_q  <= inv_q ? (acc_q + step_q) : (acc_q - step_q);
                    last_q <= (idx_nxt == last_idx_q);
                end
            end else if (i_abort) begin
                last_q <= 1'b0;
            end
        end
    end

    assign o_valid = (state_q == ST_RUN);
    assign o_busy  = (state_q == ST_RUN);
    assign o_angle = acc_q;
    assign o_index = idx_q;
    assign o_last  = last_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_cordic_twiddle_angle_gen.sv
// Bench for cordic_twiddle_angle_gen: directed streams checked against a k*STEP model.
// Latency: n/a.
// Backpressure: exercised with toggled i_ready.
module tb_cordic_twiddle_angle_gen;

    localparam int ANGLE_W   = 32;
    localparam int FRAC_W    = 16;
    localparam int MAX_LOG2N = 10;
    localparam int IDX_W     = 9;
    localparam real PI       = 3.14159265358979323846;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic [3:0]         i_stage = 4'd0;
    logic               i_inverse = 1'b0;
    logic               i_abort = 1'b0;
    logic               i_ready = 1'b0;
    logic               o_valid;
    logic [ANGLE_W-1:0] o_angle;
    logic [IDX_W-1:0]   o_index;
    logic               o_last;
    logic               o_busy;
    logic               o_err;

    always #5 i_clk = ~i_clk;

    cordic_twiddle_angle_gen #(
        .ANGLE_W   (ANGLE_W),
        .FRAC_W    (FRAC_W),
        .MAX_LOG2N (MAX_LOG2N)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .i_stage   (i_stage),
        .i_inverse (i_inverse),
        .i_abort   (i_abort),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_angle   (o_angle),
        .o_index   (o_index),
        .o_last    (o_last),
        .o_busy    (o_busy),
        .o_err     (o_err)
    );

    typedef struct {
        int angle;
        int index;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    acc_log[$];
    int    ref_log[$];
    int    n_checks = 0;
    int    n_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: actual=0x%08h (%0d) required=0x%08h (%0d) at %0t",
                     name, act, $signed(act), req, $signed(req), $time);
        end
    endtask

    function automatic int model_step(input int s);
        real v;
        v = PI * (2.0 ** FRAC_W) / (2.0 ** real'(s - 1));
        return $rtoi(v + 0.5);
    endfunction

    // Expected stream: angle k = -/+ k*STEP(s), straight multiplication.
    task automatic push_stream(input int s, input bit inv);
        int n;
        int st;
        beat_t b;
        n  = 1 << (s - 1);
        st = model_step(s);
        for (int k = 0; k < n; k++) begin
            b.angle = inv ? (k * st) : -(k * st);
            b.index = k;
            b.last  = (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    // Compare process: every accepted beat against the model, every stall for stability.
    logic               prev_stall = 1'b0;
    logic [ANGLE_W-1:0] prev_angle = '0;
    logic [IDX_W-1:0]   prev_idx = '0;
    logic               prev_last = 1'b0;

    always @(negedge i_clk) begin
        beat_t b;
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("busy_tracks_valid", {31'd0, o_busy}, {31'd0, o_valid});
            if (prev_stall) begin
                check("stall_valid", {31'd0, o_valid}, 32'd1);
                check("stall_angle", o_angle, prev_angle);
                check("stall_index", {23'd0, o_index}, {23'd0, prev_idx});
                check("stall_last", {31'd0, o_last}, {31'd0, prev_last});
            end
            if (o_valid && i_ready && !i_abort) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL unexpected_beat: actual angle=0x%08h index=%0d required no beat at %0t",
                             o_angle, o_index, $time);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_angle", o_angle, b.angle);
                    check("beat_index", {23'd0, o_index}, b.index);
                    check("beat_last", {31'd0, o_last}, {31'd0, b.last});
                end
                acc_log.push_back(int'(o_angle));
            end
            prev_stall = o_valid && !i_ready && !i_abort;
            prev_angle = o_angle;
            prev_idx   = o_index;
            prev_last  = o_last;
        end
    end

    // Called at posedge+1; leaves the start pulse one cycle wide.
    task automatic start(input int s, input bit inv);
        i_start   = 1'b1;
        i_stage   = 4'(s);
        i_inverse = inv;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("start_first_valid", {31'd0, o_valid}, 32'd1);
    endtask

    task automatic drain(input bit rnd, input int limit);
        bit done;
        done = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
            end else begin
                if (rnd) i_ready = 1'($urandom_range(0, 1));
                @(posedge i_clk); #1;
            end
        end
        if (!done) begin
            check("drain_timeout_remaining", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        check("end_valid_low", {31'd0, o_valid}, 32'd0);
        check("end_busy_low", {31'd0, o_busy}, 32'd0);
        i_ready = 1'b1;
    endtask

    task automatic wait_index(input int k, input int limit);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < limit && !hit; c++) begin
            if (o_valid && int'(o_index) == k) hit = 1'b1;
            else begin
                @(posedge i_clk); #1;
            end
        end
        check("wait_index_reached", {31'd0, hit}, 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_err"}, {31'd0, o_err}, 32'd0);
        check({tag, "_last"}, {31'd0, o_last}, 32'd0);
        check({tag, "_angle"}, o_angle, 32'd0);
        check({tag, "_index"}, {23'd0, o_index}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and model pins.
        repeat (3) @(posedge i_clk);
        #1;
        check_outputs_zero("reset");
        check("model_step6", model_step(6), 32'd6434);
        check("model_step3", model_step(3), 32'd51472);
        check("model_step1", model_step(1), 32'd205887);
        check("model_step2", model_step(2), 32'd102944);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Stage 6 forward, ready held high.
        acc_log.delete();
        i_ready = 1'b1;
        push_stream(6, 1'b0);
        start(6, 1'b0);
        drain(1'b0, 200);
        ref_log = acc_log;
        check("t1_count", ref_log.size(), 32'd32);
        if (ref_log.size() == 32) begin
            check("t1_angle0", ref_log[0], 32'h0000_0000);
            check("t1_angle1", ref_log[1], 32'hFFFF_E6DE);
            check("t1_angle2", ref_log[2], 32'hFFFF_CDBC);
            check("t1_angle31", ref_log[31], 32'hFFFC_F4E2);
        end

        // Stage 3 inverse, started the cycle after the previous stream ended.
        acc_log.delete();
        push_stream(3, 1'b1);
        start(3, 1'b1);
        drain(1'b0, 100);
        check("t2_count", acc_log.size(), 32'd4);
        if (acc_log.size() == 4) begin
            check("t2_angle1", acc_log[1], 32'd51472);
            check("t2_angle3", acc_log[3], 32'd154416);
        end

        // Stage 6 forward with random backpressure.
        acc_log.delete();
        push_stream(6, 1'b0);
        start(6, 1'b0);
        drain(1'b1, 600);
        check("t3_count", acc_log.size(), 32'd32);
        if (acc_log.size() == 32 && ref_log.size() == 32) begin
            for (int k = 0; k < 32; k++) check("t3_same_as_t1", acc_log[k], ref_log[k]);
        end

        // Stage 1: one beat, angle 0, last.
        acc_log.delete();
        push_stream(1, 1'b0);
        start(1, 1'b0);
        check("t4_last_on_first", {31'd0, o_last}, 32'd1);
        drain(1'b0, 50);
        check("t4_count", acc_log.size(), 32'd1);

        // Illegal stages 0 and 11.
        for (int t = 0; t < 2; t++) begin
            i_start = 1'b1;
            i_stage = (t == 0) ? 4'd0 : 4'd11;
            @(posedge i_clk); #1;
            i_start = 1'b0;
            check("err_pulse", {31'd0, o_err}, 32'd1);
            check("err_no_valid", {31'd0, o_valid}, 32'd0);
            @(posedge i_clk); #1;
            check("err_cleared", {31'd0, o_err}, 32'd0);
            check("err_still_idle", {31'd0, o_valid}, 32'd0);
        end

        // Mid-stream start ignored, abort at k=10, then stage 2.
        acc_log.delete();
        push_stream(6, 1'b0);
        start(6, 1'b0);
        wait_index(4, 50);
        i_start   = 1'b1;
        i_stage   = 4'd3;
        i_inverse = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_index(10, 50);
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        check("abort_valid_low", {31'd0, o_valid}, 32'd0);
        check("abort_busy_low", {31'd0, o_busy}, 32'd0);
        check("abort_beats_left", exp_q.size(), 32'd22);
        exp_q.delete();
        acc_log.delete();
        push_stream(2, 1'b0);
        start(2, 1'b0);
        drain(1'b0, 50);
        check("t6_count", acc_log.size(), 32'd2);
        if (acc_log.size() == 2) check("t6_angle1", acc_log[1], -32'sd102944);

        // Asynchronous reset mid-stream.
        push_stream(6, 1'b0);
        start(6, 1'b0);
        wait_index(5, 50);
        #1 i_rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk); #1;
            check("post_rst_idle_valid", {31'd0, o_valid}, 32'd0);
            check("post_rst_idle_busy", {31'd0, o_busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_twiddle_angle_gen.md
# cordic_twiddle_angle_gen

Parametrised twiddle-angle sequencer for the CORDIC-based FFT. It replaces the fixed per-stage angle ROMs with one block per rotator. On a start request it streams the angle sequence for any stage s: −k·π/2^(s−1) for k = 0..2^(s−1)−1, or +k·π/2^(s−1) in inverse (IFFT) mode. Output is signed fixed point with FRAC_W fraction bits, one angle per cycle under a valid/ready handshake. It sits between the stage controller and the CORDIC rotator's angle input.

## Interface
- ANGLE_W, 32, signed angle width; must satisfy ANGLE_W ≥ FRAC_W+3 (elaboration assertion).
- FRAC_W, 16, fraction bits of the angle in radians.
- MAX_LOG2N, 10, largest supported stage; max sequence length 2^(MAX_LOG2N−1).
- IDX_W, MAX_LOG2N−1 (derived, min 1), width of the angle index.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_stage  in  4  stage number s; legal range 1..MAX_LOG2N.
- i_inverse  in  1  0 = negative angles (FFT), 1 = positive angles (IFFT).
- i_abort  in  1  synchronous abort; returns to IDLE.
- i_ready  in  1  downstream accepts the current angle.
- o_valid  out  1  o_angle, o_index and o_last are valid.
- o_angle  out  ANGLE_W  signed angle, Q(ANGLE_W−FRAC_W).FRAC_W.
- o_index  out  IDX_W  k of the current angle.
- o_last  out  1  current beat is k = 2^(s−1)−1.
- o_busy  out  1  FSM is in RUN.
- o_err  out  1  one-cycle pulse on an illegal-stage start.

## Operation
- Step per stage: STEP(s) = round(π·2^FRAC_W / 2^(s−1)), held in a constant table indexed by s. With FRAC_W=16: STEP(6)=6434, STEP(3)=51472, STEP(1)=205887.
- Angle k = ∓k·STEP(s), formed by accumulation (add or subtract STEP each beat), never by multiplication. This reproduces the legacy ROM contents bit-exactly.
- Accumulator is ANGLE_W signed. |angle| < π·2^FRAC_W, so it cannot overflow under the width assertion. There is no wrap to ±π.
- FSM states:
  - IDLE: o_valid=0, o_busy=0.
  - On i_start with legal s: latch STEP(s), the sign and the last index 2^(s−1)−1; clear index and accumulator; go to RUN.
  - On i_start with s=0 or s>MAX_LOG2N: pulse o_err for one cycle; stay in IDLE.
- RUN: o_valid=1, o_busy=1.
  - Fire = o_valid & i_ready.
  - On fire with o_last=0: index+1, accumulator ± STEP.
  - On fire with o_last=1: go to IDLE.
- Backpressure: while o_valid & !i_ready, o_angle, o_index and o_last hold stable.
- i_start in RUN is ignored; no queueing. i_stage and i_inverse are sampled only at an accepted start.
- i_abort in any state: go to IDLE next cycle and drop o_valid. Abort wins over a simultaneous fire and a simultaneous start.
- Stage 1: a single beat, angle 0, with o_last=1 on that beat.
- Reset (asynchronous, any time, including mid-stream): IDLE. o_valid, o_angle, o_index, o_last, o_busy and o_err all go to 0.

## Timing
- Start latency: i_start accepted in cycle t gives o_valid=1 with k=0 and angle 0 in cycle t+1.
- Throughput: one angle per cycle while i_ready=1. A stage-s stream takes 2^(s−1) cycles plus stalls.
- After the last beat fires in cycle u: o_valid=0 and o_busy=0 in cycle u+1. A new i_start is accepted in u+1 and gives its first beat in u+2.
- o_err is asserted in the cycle after the illegal start.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `fft_cordic_pkg` holds:
  - the ANGLE_W / FRAC_W defaults;
  - the function `twiddle_step(s, frac_w)` returning round(π·2^frac_w/2^(s−1)), used to build the step table;
  - the enum for the FSM states (IDLE, RUN).
- One natural sub-module: `angle_step_lut`, a combinational STEP(s) table of MAX_LOG2N entries. The rest stays flat.

## Test plan
- Stage 6, i_inverse=0, i_ready=1: 32 beats.
  - Angles 0, 0xFFFFE6DE, 0xFFFFCDBC, …, 0xFFFCF4E2.
  - o_index runs 0..31; o_last only at 31; o_valid drops the next cycle.
- Stage 3, i_inverse=1: angles 0, 51472, 102944, 154416; o_last on 154416.
- Stage 6 with i_ready toggled pseudo-randomly: the accepted sequence is identical to the first test, and outputs are stable during every stall.
- Stage 1: a single beat, angle 0 with o_last=1. Stage 0 and stage 11 (MAX_LOG2N=10): one o_err pulse each, o_valid stays 0.
- i_start pulsed mid-stream is ignored. i_abort at k=10 gives o_valid=0 the next cycle. A following start of stage 2 gives angles 0, −102944.
- i_rst_n asserted at k=5 of a stage-6 stream clears all outputs immediately. After release, idle until i_start.
